// File: rtl/uc_pkg.sv
// Shared definitions for the sequencing control unit.
// Contents:
//   - major opcode constants (opcode[5:2] when opcode[5]=0)
//   - sub-op constants (opcode[1:0] for the CTRL and SYS groups)
//   - regfile and output source select codes
//   - FSM state encoding
//   - control vector and decode result structs
package uc_pkg;

  localparam logic [3:0] OP_LI   = 4'b0000;
  localparam logic [3:0] OP_LD   = 4'b0001;
  localparam logic [3:0] OP_ST   = 4'b0010;
  localparam logic [3:0] OP_IN   = 4'b0011;
  localparam logic [3:0] OP_OUTR = 4'b0100;
  localparam logic [3:0] OP_OUTI = 4'b0101;
  localparam logic [3:0] OP_CTRL = 4'b0110;
  localparam logic [3:0] OP_SYS  = 4'b0111;

  // CTRL group sub-ops
  localparam logic [1:0] SUB_J    = 2'b00;
  localparam logic [1:0] SUB_JZ   = 2'b01;
  localparam logic [1:0] SUB_JNZ  = 2'b10;
  localparam logic [1:0] SUB_CALL = 2'b11;

  // SYS group sub-ops
  localparam logic [1:0] SUB_RET  = 2'b00;
  localparam logic [1:0] SUB_NOP  = 2'b01;
  localparam logic [1:0] SUB_HALT = 2'b10;
  localparam logic [1:0] SUB_NOP2 = 2'b11;

  // Regfile write source
  localparam logic [1:0] INM_ALU = 2'd0;
  localparam logic [1:0] INM_IMM = 2'd1;
  localparam logic [1:0] INM_MEM = 2'd2;
  localparam logic [1:0] INM_IN  = 2'd3;

  // Output register source
  localparam logic [1:0] OUT_RD1 = 2'd0;
  localparam logic [1:0] OUT_IMM = 2'd1;

  typedef enum logic [2:0] {
    ST_RUN      = 3'd0,
    ST_WAIT_IN  = 3'd1,
    ST_WAIT_OUT = 3'd2,
    ST_RET_SKIP = 3'd3,
    ST_HALT     = 3'd4
  } state_t;

  // Every datapath control line driven by the unit.
  typedef struct packed {
    logic       pc_we;
    logic       s_inc;
    logic       s_stack;
    logic       push;
    logic       pop;
    logic       we3;
    logic       wez;
    logic       we4;
    logic       we_out;
    logic [1:0] s_inm;
    logic [1:0] s_in;
    logic [1:0] s_out;
    logic [2:0] op_alu;
    logic [1:0] in_ack;
  } ctrl_t;

  // Single-cycle decode result plus the instruction class flags the
  // sequencer needs in order to apply stalls and stack checks.
  typedef struct packed {
    ctrl_t ctrl;
    logic  is_in;
    logic  is_out;
    logic  is_call;
    logic  is_ret;
    logic  is_halt;
  } dec_t;

  // Control vector with every enable off and the PC source at PC+1.
  function automatic ctrl_t ctrl_idle();
    ctrl_t c;
    c       = '0;
    c.s_inc = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/uc_decode.sv
// Pure combinational opcode decode.
// Ports:
//   opcode [5:0] in  : instr[15:10]
//   z            in  : registered zero flag (for JZ/JNZ)
//   dec          out : default control vector as if the instruction runs
//                      unstalled this cycle, plus instruction class flags
module uc_decode
  import uc_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic       z,
  output dec_t       dec
);

  always_comb begin
    dec          = '0;
    dec.ctrl     = ctrl_idle();
    dec.ctrl.pc_we = 1'b1;

    if (opcode[5]) begin
      dec.ctrl.op_alu = opcode[4:2];
      dec.ctrl.we3    = 1'b1;
      dec.ctrl.wez    = 1'b1;
      dec.ctrl.s_inm  = INM_ALU;
    end else begin
      case (opcode[5:2])
        OP_LI: begin
          dec.ctrl.s_inm = INM_IMM;
          dec.ctrl.we3   = 1'b1;
        end
        OP_LD: begin
          dec.ctrl.s_inm = INM_MEM;
          dec.ctrl.we3   = 1'b1;
        end
        OP_ST: dec.ctrl.we4 = 1'b1;
        OP_IN: begin
          dec.ctrl.s_in  = {1'b0, opcode[0]};
          dec.ctrl.s_inm = INM_IN;
          dec.ctrl.we3   = 1'b1;
          dec.is_in      = 1'b1;
        end
        OP_OUTR: begin
          dec.ctrl.s_out  = OUT_RD1;
          dec.ctrl.we_out = 1'b1;
          dec.is_out      = 1'b1;
        end
        OP_OUTI: begin
          dec.ctrl.s_out  = OUT_IMM;
          dec.ctrl.we_out = 1'b1;
          dec.is_out      = 1'b1;
        end
        OP_CTRL: begin
          case (opcode[1:0])
            SUB_J:   dec.ctrl.s_inc = 1'b0;
            SUB_JZ:  dec.ctrl.s_inc = ~z;
            SUB_JNZ: dec.ctrl.s_inc = z;
            default: begin
              dec.ctrl.s_inc = 1'b0;
              dec.ctrl.push  = 1'b1;
              dec.is_call    = 1'b1;
            end
          endcase
        end
        OP_SYS: begin
          case (opcode[1:0])
            SUB_RET: begin
              dec.ctrl.pop     = 1'b1;
              dec.ctrl.s_stack = 1'b1;
              dec.is_ret       = 1'b1;
            end
            SUB_HALT: begin
              dec.ctrl.pc_we = 1'b0;
              dec.is_halt    = 1'b1;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/uc_seq.sv
// Sequencing control unit for the 8-bit single-cycle CPU.
// Decode is single-cycle; this block layers stalls, the two-cycle return,
// stack depth tracking with fault trapping and a HALT/resume state on top.
//
// Handshakes:
//   in_ready[p] high means input port p holds data; the unit consumes it in
//   a cycle where it writes the regfile and pulses in_ack[p] for that cycle
//   only. out_busy high means the output side refuses a write; we_out is
//   only asserted in a cycle where out_busy is low. A stalled instruction
//   holds the PC (pc_we=0) and re-tries every cycle.
//
// Ports:
//   clk, reset (async, active low)
//   opcode[5:0], z, in_ready[1:0], out_busy, resume   : inputs
//   pc_we, s_inc, s_stack, pushsignal, popsignal,
//   we3, wez, we4, we_out, s_inm, s_in, s_out,
//   op_alu, in_ack                                    : datapath controls
//   halted, err                                       : status
//   state, depth                                      : debug visibility
module uc_seq
  import uc_pkg::*;
#(
  parameter  int STACK_DEPTH = 16,
  localparam int DW          = $clog2(STACK_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [5:0]    opcode,
  input  logic          z,
  input  logic [1:0]    in_ready,
  input  logic          out_busy,
  input  logic          resume,
  output logic          pc_we,
  output logic          s_inc,
  output logic          s_stack,
  output logic          pushsignal,
  output logic          popsignal,
  output logic          we3,
  output logic          wez,
  output logic          we4,
  output logic          we_out,
  output logic [1:0]    s_inm,
  output logic [1:0]    s_in,
  output logic [1:0]    s_out,
  output logic [2:0]    op_alu,
  output logic [1:0]    in_ack,
  output logic          halted,
  output logic          err,
  output state_t        state,
  output logic [DW-1:0] depth
);

  localparam logic [DW-1:0] FULL = DW'(STACK_DEPTH);

  dec_t   dec;
  ctrl_t  c;
  state_t state_nx;
  logic   err_set;
  logic   in_sel;

  uc_decode u_decode (
    .opcode (opcode),
    .z      (z),
    .dec    (dec)
  );

  assign in_sel = opcode[0];

  always_comb begin
    c        = dec.ctrl;
    state_nx = state;
    err_set  = 1'b0;

    case (state)
      ST_RUN: begin
        if (dec.is_in) begin
          if (in_ready[in_sel]) begin
            c.in_ack[in_sel] = 1'b1;
          end else begin
            c.pc_we  = 1'b0;
            c.we3    = 1'b0;
            state_nx = ST_WAIT_IN;
          end
        end
        if (dec.is_out && out_busy) begin
          c.pc_we  = 1'b0;
          c.we_out = 1'b0;
          state_nx = ST_WAIT_OUT;
        end
        if (dec.is_call && depth == FULL) begin
          c.push   = 1'b0;
          c.pc_we  = 1'b0;
          err_set  = 1'b1;
          state_nx = ST_HALT;
        end
        if (dec.is_ret) begin
          if (depth == '0) begin
            c.pop     = 1'b0;
            c.s_stack = 1'b0;
            c.pc_we   = 1'b0;
            err_set   = 1'b1;
            state_nx  = ST_HALT;
          end else begin
            state_nx = ST_RET_SKIP;
          end
        end
        if (dec.is_halt) state_nx = ST_HALT;
      end

      // The PC is frozen, so the IN instruction is still on opcode.
      ST_WAIT_IN: begin
        if (in_ready[in_sel]) begin
          c.in_ack[in_sel] = 1'b1;
          state_nx         = ST_RUN;
        end else begin
          c.pc_we = 1'b0;
          c.we3   = 1'b0;
        end
      end

      ST_WAIT_OUT: begin
        if (!out_busy) begin
          state_nx = ST_RUN;
        end else begin
          c.pc_we  = 1'b0;
          c.we_out = 1'b0;
        end
      end

      // PC holds the CALL address after the pop; step past it while
      // ignoring whatever that CALL opcode would decode to.
      ST_RET_SKIP: begin
        c        = ctrl_idle();
        c.pc_we  = 1'b1;
        state_nx = ST_RUN;
      end

      ST_HALT: begin
        c = ctrl_idle();
        if (resume && !err) begin
          c.pc_we  = 1'b1;
          state_nx = ST_RUN;
        end
      end

      default: begin
        c        = ctrl_idle();
        state_nx = ST_RUN;
      end
    endcase

    // Reset is asynchronous, so the enables must drop with it rather than
    // wait for the state register to be sampled.
    if (!reset) begin
      c        = ctrl_idle();
      state_nx = ST_RUN;
      err_set  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_RUN;
      depth <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nx;
      err   <= err | err_set;
      // push is only granted below FULL and pop only above zero, so the
      // counter cannot wrap; push and pop are mutually exclusive by decode.
      if (c.push)     depth <= depth + 1'b1;
      else if (c.pop) depth <= depth - 1'b1;
    end
  end

  assign pc_we      = c.pc_we;
  assign s_inc      = c.s_inc;
  assign s_stack    = c.s_stack;
  assign pushsignal = c.push;
  assign popsignal  = c.pop;
  assign we3        = c.we3;
  assign wez        = c.wez;
  assign we4        = c.we4;
  assign we_out     = c.we_out;
  assign s_inm      = c.s_inm;
  assign s_in       = c.s_in;
  assign s_out      = c.s_out;
  assign op_alu     = c.op_alu;
  assign in_ack     = c.in_ack;
  assign halted     = reset && (state == ST_HALT);

endmodule

// File: doc/uc_seq.md
Name: uc_seq

Overview:
- Sequencing control unit for the 8-bit single-cycle CPU datapath (PC, regfile, ALU, Z flip-flop, return stack, data memory, 2 input ports, 4 output registers).
- Decodes the 6-bit opcode and drives every datapath control line.
- Adds sequential behaviour on top of single-cycle decode:
  - stalls on input/output handshakes;
  - runs a two-cycle return sequence;
  - tracks stack depth with overflow/underflow trapping;
  - supports a HALT state with resume.

Parameters:
STACK_DEPTH, 16, return-stack entries; the depth counter width is clog2(STACK_DEPTH+1).

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
opcode  in  6  instr[15:10] from program memory
z  in  1  registered zero flag
in_ready  in  2  per input port: data available (bit0 = in1, bit1 = in2)
out_busy  in  1  output side cannot accept a write
resume  in  1  leave HALT (ignored when err=1)
pc_we  out  1  PC write enable (datapath PC register gated by this)
s_inc  out  1  PC source: 0 = jump target instr[9:0], 1 = PC+1
s_stack  out  1  1 = PC loads stack top
pushsignal, popsignal  out  1  stack push/pop
we3  out  1  regfile write
wez  out  1  Z flag load
we4  out  1  data memory write
we_out  out  1  output register write (port from instr[1:0])
s_inm  out  2  regfile write source: 0 ALU, 1 immediate, 2 memory, 3 input
s_in  out  2  input port select
s_out  out  2  output source: 0 rd1, 1 immediate
op_alu  out  3  ALU operation
in_ack  out  2  one-cycle pulse on the port whose data was consumed
halted  out  1  in HALT state
err  out  1  sticky stack fault

Behaviour:
- Decode:
  - opcode[5]=1 is ALU class: op_alu=opcode[4:2], we3=1, wez=1, s_inm=0.
  - Otherwise the major code is opcode[5:2]:
    - 0000 LI: s_inm=1, we3.
    - 0001 LD: s_inm=2, we3.
    - 0010 ST: we4.
    - 0011 IN: s_in={0,opcode[0]}, s_inm=3, we3.
    - 0100 OUTR: s_out=0, we_out.
    - 0101 OUTI: s_out=1, we_out.
    - 0110 uses sub-op opcode[1:0]: 00 J, 01 JZ (taken if z=1), 10 JNZ (taken if z=0), 11 CALL.
    - 0111 uses sub-op opcode[1:0]: 00 RET, 01 NOP, 10 HALT, 11 NOP.
- Defaults: all enables 0, s_inc=1, s_stack=0, pc_we=1, selects 0.
- Taken jump or CALL: s_inc=0. Not-taken jump: PC+1.
- States: RUN, WAIT_IN, WAIT_OUT, RET_SKIP, HALT. Outputs are combinational from state and inputs; state, depth and err are registered.
- While reset=0:
  - state=RUN, depth=0, err=0;
  - every enable forced to 0, including pc_we, we3, wez, we4, we_out, push, pop and in_ack;
  - halted=0.
  - Reset mid-stall or mid-RET_SKIP aborts cleanly.
- IN:
  - If in_ready[sel]=1 in RUN: execute in the same cycle and pulse in_ack[sel].
  - Otherwise go to WAIT_IN with pc_we=0 and we3=0.
  - In WAIT_IN, the first cycle in_ready[sel]=1 performs the write, pulses in_ack, advances the PC, and returns to RUN. Zero added latency when data is ready.
- OUTR/OUTI:
  - If out_busy=1: go to WAIT_OUT (pc_we=0, we_out=0).
  - Write and advance on the first cycle out_busy=0.
- CALL:
  - If depth<STACK_DEPTH: push, jump, depth+1.
  - If depth==STACK_DEPTH: no push, pc_we=0, set err, go to HALT.
- RET:
  - If depth>0: pop, s_stack=1, pc_we=1, depth-1, go to RET_SKIP.
  - If depth==0: no pop, pc_we=0, set err, go to HALT.
- RET_SKIP (the PC now holds the CALL address): s_inc=1, pc_we=1, all other enables 0 regardless of opcode; return to RUN. RET costs 2 cycles.
- HALT:
  - Executing HALT gives pc_we=0 and moves to HALT.
  - In HALT: halted=1, pc_we=0, all enables 0.
  - resume=1 with err=0: pc_we=1, s_inc=1, return to RUN.
  - With err=1, only reset exits.
- Push and pop are never asserted in the same cycle. The depth counter never wraps.

Decomposition:
- Shared package uc_pkg:
  - major opcode constants (OP_LI, OP_LD, OP_ST, OP_IN, OP_OUTR, OP_OUTI, OP_CTRL, OP_SYS);
  - sub-op constants;
  - state encoding;
  - s_inm and s_out select constants.
- One combinational sub-module uc_decode: opcode and z in, default control vector out.
- uc_seq holds the FSM, depth counter and err, and overrides the decode outputs per state.

Test Plan:
- Reset low mid-WAIT_IN then release -> all enables 0 during reset; RUN, depth=0, err=0 after release.
- Opcode 110100 (ALU op 5) -> op_alu=5, we3=1, wez=1, s_inm=0, pc_we=1, s_inc=1 in the same cycle.
- IN port 1 (opcode 001101) with in_ready=00 for 3 cycles, then 10 -> pc_we=0 and we3=0 for 3 cycles; 4th cycle we3=1, s_inm=3, s_in=1, in_ack=10, pc_we=1; back in RUN.
- CALL then RET -> CALL: push, s_inc=0, depth 1. RET: pop, s_stack=1, depth 0. Next cycle RET_SKIP: s_inc=1, we3=0 even though the opcode is CALL.
- 16 nested CALLs then a 17th -> 17th: no push, err=1, halted=1. resume=1 stays halted.
- JZ with z=0 then JNZ with z=0 -> JZ gives s_inc=1; JNZ gives s_inc=0. HALT then resume pulse -> one pc_we cycle with s_inc=1, back in RUN.
